// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART transmit FIFO write port between NREQ requesters.
// A requester keeps the grant until its last byte is accepted. Two limits force a release:
// MAXLEN accepted bytes per grant, and TIMEOUT consecutive idle cycles from the owner.
module uart_tx_arbiter #(
  parameter int unsigned nbits   = 8,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAXLEN  = 16,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*nbits-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       ack,
  output logic                  twr_en,
  output logic [nbits-1:0]      twr_data,
  input  logic                  tx_full,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  trunc,
  output logic                  abort
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(MAXLEN + 1);
  // Keep the idle counter at least one bit wide when the timeout is disabled.
  localparam int unsigned IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            busy_q, busy_d;
  logic            trunc_q, trunc_d;
  logic            abort_q, abort_d;

  logic             own_req, own_last;
  logic [nbits-1:0] own_data;
  logic             found;
  logic [PW-1:0]    winner;
  int               scan_idx;
  logic             acc, rel_end, rel_trunc, rel_abort;

  // Select the current owner's request, last flag and byte.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (owner_q == PW'(i)) begin
        own_req  = req[i];
        own_last = req_last[i];
        own_data = req_data[i*nbits +: nbits];
      end
    end
  end

  // Round-robin scan: first set request at or above ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= int'(NREQ)) scan_idx = scan_idx - int'(NREQ);
      if (!found && req[PW'(scan_idx)]) begin
        found  = 1'b1;
        winner = PW'(scan_idx);
      end
    end
  end

  // Next-state logic and the combinational FIFO write port.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    busy_d    = busy_q;
    trunc_d   = 1'b0;
    abort_d   = 1'b0;
    acc       = 1'b0;
    rel_end   = 1'b0;
    rel_trunc = 1'b0;
    rel_abort = 1'b0;
    ack       = '0;
    twr_en    = 1'b0;
    twr_data  = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StBusy;
          owner_d = winner;
          busy_d  = 1'b1;
          cnt_d   = '0;
          idle_d  = '0;
          for (int i = 0; i < int'(NREQ); i++) grant_d[i] = (winner == PW'(i));
        end
      end
      StBusy: begin
        acc = own_req & ~tx_full;
        if (acc) begin
          twr_en   = 1'b1;
          ack      = grant_q;
          twr_data = own_data;
          cnt_d    = cnt_q + CW'(1);
        end
        // A full-FIFO stall with req held is not idle time.
        if (own_req || TIMEOUT == 0) idle_d = '0;
        else                         idle_d = idle_q + IW'(1);
        rel_end   = acc & own_last;
        rel_trunc = acc & ~own_last & (cnt_q == CW'(MAXLEN - 1));
        rel_abort = (TIMEOUT != 0) & ~own_req & (idle_q == IW'(TIMEOUT - 1));
        if (rel_end || rel_trunc || rel_abort) begin
          state_d = StIdle;
          grant_d = '0;
          busy_d  = 1'b0;
          trunc_d = rel_trunc;
          abort_d = rel_abort;
          // Released owner becomes lowest priority.
          if (owner_q == PW'(NREQ - 1)) ptr_d = '0;
          else                          ptr_d = owner_q + PW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      busy_q  <= 1'b0;
      trunc_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      busy_q  <= busy_d;
      trunc_q <= trunc_d;
      abort_q <= abort_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign trunc = trunc_q;
  assign abort = abort_q;

endmodule
